// File: rtl/pll_lock_poller_pkg.sv
// Shared types and widths for the PLL lock poller: FSM encoding, bus/status
// field widths and the status match helper.
package pll_lock_poller_pkg;

  localparam int STATUS_W   = 8;
  localparam int RDATA_W    = 32;
  localparam int POLL_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EVAL,
    GAP,
    FIN
  } state_t;

  function automatic logic status_match(input logic [STATUS_W-1:0] status,
                                        input logic [STATUS_W-1:0] mask);
    return (status & mask) == mask;
  endfunction

endpackage

// File: rtl/poll_gap_timer.sv
// Loadable down-counter; expire is high on the last cycle of a loaded count,
// so a load of N gives an expire on the Nth cycle after the load edge.
module poll_gap_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/pll_lock_poller.sv
// Avalon-MM read initiator that polls an 8-bit status PIO until the masked bits
// are stable-high or a poll budget runs out. Define PLL_LOCK_POLLER_MONITOR_EN
// to keep polling after lock and report a loss of lock on lock_lost.
module pll_lock_poller
  import pll_lock_poller_pkg::*;
#(
  parameter int ADDR_W        = 2,
  parameter int POLL_ADDR     = 0,
  parameter int READ_LATENCY  = 1,
  parameter int POLL_GAP      = 16,
  parameter int STABLE_POLLS  = 4,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [STATUS_W-1:0]   lock_mask,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [RDATA_W-1:0]    avm_readdata,
  output logic                  busy,
  output logic                  done,
  output logic                  locked,
  output logic                  timeout,
  output logic [POLL_CNT_W-1:0] poll_count
`ifdef PLL_LOCK_POLLER_MONITOR_EN
  ,
  output logic                  lock_lost
`endif
);

`ifdef PLL_LOCK_POLLER_MONITOR_EN
  localparam bit MONITOR = 1'b1;
`else
  localparam bit MONITOR = 1'b0;
`endif

  localparam int TMR_MAX = (POLL_GAP > READ_LATENCY) ? POLL_GAP : READ_LATENCY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int MC_W    = $clog2(STABLE_POLLS + 1);

  localparam logic [TMR_W-1:0]      LAT_LOAD    = TMR_W'(READ_LATENCY);
  localparam logic [TMR_W-1:0]      GAP_LOAD    = TMR_W'(POLL_GAP);
  localparam logic [MC_W-1:0]       STABLE_CNT  = MC_W'(STABLE_POLLS);
  localparam logic [POLL_CNT_W-1:0] TIMEOUT_CNT = POLL_CNT_W'(TIMEOUT_POLLS);

  state_t                state;
  state_t                state_next;
  logic [STATUS_W-1:0]   mask_q;
  logic [STATUS_W-1:0]   status_q;
  logic [MC_W-1:0]       match_cnt;
  logic [MC_W-1:0]       match_cnt_next;
  logic                  tmr_load;
  logic [TMR_W-1:0]      tmr_value;
  logic                  tmr_expire;
  logic                  accept;
  logic                  start_ok;
  logic                  poll_hit;
  logic                  monitoring;
  logic                  go_gap;
  logic                  lock_now;
  logic                  timeout_now;
  logic                  lost_now;
  logic                  unused_readdata;

  assign avm_address     = ADDR_W'(POLL_ADDR);
  assign avm_read        = (state == ISSUE);
  assign busy            = (state != IDLE);
  assign done            = (state == FIN);
  assign accept          = (state == ISSUE) && !avm_waitrequest;
  assign start_ok        = (state == IDLE) && start;
  assign poll_hit        = status_match(status_q, mask_q);
  assign monitoring      = MONITOR && locked;
  assign unused_readdata = ^avm_readdata[RDATA_W-1:STATUS_W];

  poll_gap_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (tmr_load),
    .load_value(tmr_value),
    .expire    (tmr_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Once locked in monitor mode, EVAL only watches for a mismatching poll.
  always_comb begin
    state_next     = state;
    tmr_load       = 1'b0;
    tmr_value      = LAT_LOAD;
    match_cnt_next = match_cnt;
    go_gap         = 1'b0;
    lock_now       = 1'b0;
    timeout_now    = 1'b0;
    lost_now       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ISSUE;
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          tmr_load   = 1'b1;
          tmr_value  = LAT_LOAD;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (tmr_expire) state_next = EVAL;
      end
      EVAL: begin
        if (poll_hit) begin
          match_cnt_next = (match_cnt == STABLE_CNT) ? match_cnt : match_cnt + 1'b1;
        end else begin
          match_cnt_next = '0;
        end
        if (monitoring) begin
          if (poll_hit) begin
            go_gap = 1'b1;
          end else begin
            lost_now   = 1'b1;
            state_next = FIN;
          end
        end else if (match_cnt_next == STABLE_CNT) begin
          lock_now = 1'b1;
          if (MONITOR) go_gap = 1'b1;
          else state_next = FIN;
        end else if (poll_count == TIMEOUT_CNT) begin
          timeout_now = 1'b1;
          state_next  = FIN;
        end else begin
          go_gap = 1'b1;
        end
      end
      GAP: begin
        if (tmr_expire) state_next = ISSUE;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (go_gap) begin
      state_next = GAP;
      tmr_load   = 1'b1;
      tmr_value  = GAP_LOAD;
    end
  end

  // Results are sticky until the next accepted start; poll_count saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      status_q   <= '0;
      match_cnt  <= '0;
      poll_count <= '0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else if (start_ok) begin
      mask_q     <= lock_mask;
      match_cnt  <= '0;
      poll_count <= '0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (accept && (poll_count != '1)) poll_count <= poll_count + 1'b1;
      if ((state == WAIT) && tmr_expire) status_q <= avm_readdata[STATUS_W-1:0];
      if (state == EVAL) match_cnt <= match_cnt_next;
      if (lock_now) locked <= 1'b1;
      else if (lost_now) locked <= 1'b0;
      if (timeout_now) timeout <= 1'b1;
    end
  end

`ifdef PLL_LOCK_POLLER_MONITOR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost <= 1'b0;
    end else if (start_ok) begin
      lock_lost <= 1'b0;
    end else if (lost_now) begin
      lock_lost <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_poller.sv
// Directed bench for pll_lock_poller: instance 0 uses READ_LATENCY=1/POLL_GAP=16,
// instance 1 uses READ_LATENCY=3/POLL_GAP=2; both use TIMEOUT_POLLS=8.
module tb_pll_lock_poller;

`ifdef PLL_LOCK_POLLER_MONITOR_EN
  localparam bit MONITOR = 1'b1;
`else
  localparam bit MONITOR = 1'b0;
`endif
  localparam int EXP_DONE_AT_LOCK = MONITOR ? 0 : 1;
  localparam int EXP_BUSY_AT_LOCK = MONITOR ? 1 : 0;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEFE;

  logic        clk;
  logic        reset_n;
  logic        start       [2];
  logic [7:0]  lock_mask   [2];
  logic [1:0]  avm_address [2];
  logic        avm_read    [2];
  logic        wait_req    [2];
  logic [31:0] rdata       [2];
  logic        busy        [2];
  logic        done_s      [2];
  logic        locked_s    [2];
  logic        timeout_s   [2];
  logic [15:0] poll_count  [2];
`ifdef PLL_LOCK_POLLER_MONITOR_EN
  logic        lock_lost   [2];
`endif

  int n_cmp;
  int n_fail;
  int cyc;
  int acc_total [2];
  int done_total [2];
  int rdh_total [2];
  int cur_stall [2];
  int lat_cnt [2];
  int acc_cyc [2][256];
  int base_acc [2];
  int base_done [2];
  int base_rdh [2];
  int stall_cfg [2];
  bit force_zero [2];
  logic [31:0] pat [2][16];

  pll_lock_poller #(.READ_LATENCY(1), .POLL_GAP(16), .TIMEOUT_POLLS(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .lock_mask(lock_mask[0]),
    .avm_address(avm_address[0]), .avm_read(avm_read[0]),
    .avm_waitrequest(wait_req[0]), .avm_readdata(rdata[0]),
    .busy(busy[0]), .done(done_s[0]), .locked(locked_s[0]),
    .timeout(timeout_s[0]), .poll_count(poll_count[0])
`ifdef PLL_LOCK_POLLER_MONITOR_EN
    , .lock_lost(lock_lost[0])
`endif
  );

  pll_lock_poller #(.READ_LATENCY(3), .POLL_GAP(2), .TIMEOUT_POLLS(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .lock_mask(lock_mask[1]),
    .avm_address(avm_address[1]), .avm_read(avm_read[1]),
    .avm_waitrequest(wait_req[1]), .avm_readdata(rdata[1]),
    .busy(busy[1]), .done(done_s[1]), .locked(locked_s[1]),
    .timeout(timeout_s[1]), .poll_count(poll_count[1])
`ifdef PLL_LOCK_POLLER_MONITOR_EN
    , .lock_lost(lock_lost[1])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] slave_word(input int i, input int idx);
    if (force_zero[i]) return 32'h0;
    return pat[i][(idx > 15) ? 15 : idx];
  endfunction

  // Slave model: stalls the first read of a run, then returns garbage until
  // exactly READ_LATENCY cycles after acceptance.
  initial begin
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      wait_req[i] = 1'b0;
      rdata[i] = GARBAGE;
      acc_total[i] = 0; done_total[i] = 0; rdh_total[i] = 0;
      cur_stall[i] = 0; lat_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (done_s[i]) done_total[i]++;
        if (avm_read[i]) rdh_total[i]++;
        if (lat_cnt[i] > 0) begin
          lat_cnt[i]--;
          rdata[i] = (lat_cnt[i] == 0) ? slave_word(i, acc_total[i] - 1 - base_acc[i]) : GARBAGE;
        end else begin
          rdata[i] = GARBAGE;
        end
        if (avm_read[i]) begin
          if ((acc_total[i] == base_acc[i]) && (cur_stall[i] < stall_cfg[i])) begin
            wait_req[i] = 1'b1;
            cur_stall[i]++;
          end else begin
            wait_req[i] = 1'b0;
            cur_stall[i] = 0;
            if (acc_total[i] < 256) acc_cyc[i][acc_total[i]] = cyc;
            acc_total[i]++;
            lat_cnt[i] = (i == 0) ? 1 : 3;
          end
        end else begin
          wait_req[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [7:0] mask, input int stall);
    stall_cfg[i] = stall;
    base_acc[i]  = acc_total[i];
    base_done[i] = done_total[i];
    base_rdh[i]  = rdh_total[i];
    lock_mask[i] = mask;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic waitResult(input int i);
    bit finished = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ((done_total[i] != base_done[i]) || (MONITOR && (locked_s[i] === 1'b1))) begin
        finished = 1'b1;
        break;
      end
    end
    checkOutput("run_ends", 32'(finished), 32'd1);
  endtask

  task automatic lockEpilogue(input int i);
`ifdef PLL_LOCK_POLLER_MONITOR_EN
    int snap;
    bit seen = 1'b0;
    snap = done_total[i];
    force_zero[i] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (done_total[i] != snap) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("mon_done", 32'(seen), 32'd1);
    checkOutput("mon_lock_lost", 32'(lock_lost[i]), 32'd1);
    checkOutput("mon_locked", 32'(locked_s[i]), 32'd0);
    tick();
    checkOutput("mon_busy", 32'(busy[i]), 32'd0);
    force_zero[i] = 1'b0;
`else
    tick();
    checkOutput("idle_busy", 32'(busy[i]), 32'd0);
`endif
  endtask

  initial begin
    bit found;
    n_cmp = 0;
    n_fail = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; lock_mask[i] = 8'h00; stall_cfg[i] = 0; force_zero[i] = 1'b0;
      base_acc[i] = 0; base_done[i] = 0; base_rdh[i] = 0;
      for (int k = 0; k < 16; k++) pat[i][k] = 32'h0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_busy", 32'(busy[i]), 32'd0);
      checkOutput("rst_done", 32'(done_s[i]), 32'd0);
      checkOutput("rst_locked", 32'(locked_s[i]), 32'd0);
      checkOutput("rst_timeout", 32'(timeout_s[i]), 32'd0);
      checkOutput("rst_poll_count", 32'(poll_count[i]), 32'd0);
      checkOutput("rst_read", 32'(avm_read[i]), 32'd0);
      checkOutput("rst_address", 32'(avm_address[i]), 32'd0);
    end
    reset_n = 1'b1;
    tick();

    $display("[TB] lock after 3-cycle stall");
    for (int k = 0; k < 16; k++) pat[0][k] = 32'h0000_0001;
    applyStimulus(0, 8'h01, 3);
    waitResult(0);
    checkOutput("stall_locked", 32'(locked_s[0]), 32'd1);
    checkOutput("stall_timeout", 32'(timeout_s[0]), 32'd0);
    checkOutput("stall_poll_count", 32'(poll_count[0]), 32'd4);
    checkOutput("stall_accepts", 32'(acc_total[0] - base_acc[0]), 32'd4);
    checkOutput("stall_read_cycles", 32'(rdh_total[0] - base_rdh[0]), 32'd7);
    for (int k = 0; k < 3; k++)
      checkOutput("spacing_a", 32'(acc_cyc[0][base_acc[0]+k+1] - acc_cyc[0][base_acc[0]+k]), 32'd19);
    tick();
    checkOutput("stall_done_count", 32'(done_total[0] - base_done[0]), 32'(EXP_DONE_AT_LOCK));
    checkOutput("stall_busy", 32'(busy[0]), 32'(EXP_BUSY_AT_LOCK));
    lockEpilogue(0);

    $display("[TB] glitchy lock");
    for (int k = 0; k < 16; k++) pat[0][k] = 32'hFFFF_FF03;
    pat[0][2] = 32'hFFFF_FF01;
    applyStimulus(0, 8'h03, 0);
    checkOutput("start_clears_locked", 32'(locked_s[0]), 32'd0);
    checkOutput("start_clears_count", 32'(poll_count[0]), 32'd0);
    checkOutput("start_sets_busy", 32'(busy[0]), 32'd1);
`ifdef PLL_LOCK_POLLER_MONITOR_EN
    checkOutput("start_clears_lock_lost", 32'(lock_lost[0]), 32'd0);
`endif
    waitResult(0);
    checkOutput("glitch_locked", 32'(locked_s[0]), 32'd1);
    checkOutput("glitch_poll_count", 32'(poll_count[0]), 32'd7);
    checkOutput("glitch_accepts", 32'(acc_total[0] - base_acc[0]), 32'd7);
    tick();
    checkOutput("glitch_done_count", 32'(done_total[0] - base_done[0]), 32'(EXP_DONE_AT_LOCK));
    lockEpilogue(0);

    $display("[TB] timeout");
    for (int k = 0; k < 16; k++) pat[0][k] = 32'h0;
    applyStimulus(0, 8'h01, 0);
    waitResult(0);
    checkOutput("to_timeout", 32'(timeout_s[0]), 32'd1);
    checkOutput("to_locked", 32'(locked_s[0]), 32'd0);
    checkOutput("to_poll_count", 32'(poll_count[0]), 32'd8);
    checkOutput("to_accepts", 32'(acc_total[0] - base_acc[0]), 32'd8);
    repeat (40) tick();
    checkOutput("to_done_count", 32'(done_total[0] - base_done[0]), 32'd1);
    checkOutput("to_no_more_reads", 32'(rdh_total[0] - base_rdh[0]), 32'd8);
    checkOutput("to_busy", 32'(busy[0]), 32'd0);
    checkOutput("to_timeout_sticky", 32'(timeout_s[0]), 32'd1);

    $display("[TB] zero mask");
    applyStimulus(0, 8'h00, 0);
    waitResult(0);
    checkOutput("mask0_locked", 32'(locked_s[0]), 32'd1);
    checkOutput("mask0_timeout", 32'(timeout_s[0]), 32'd0);
    checkOutput("mask0_poll_count", 32'(poll_count[0]), 32'd4);
    lockEpilogue(0);

    $display("[TB] start while busy");
    for (int k = 0; k < 16; k++) pat[0][k] = 32'h0000_0001;
    applyStimulus(0, 8'h01, 0);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (acc_total[0] - base_acc[0] == 2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("busy_reach_poll2", 32'(found), 32'd1);
    lock_mask[0] = 8'hFF;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    waitResult(0);
    checkOutput("restart_locked", 32'(locked_s[0]), 32'd1);
    checkOutput("restart_poll_count", 32'(poll_count[0]), 32'd4);
    checkOutput("restart_accepts", 32'(acc_total[0] - base_acc[0]), 32'd4);
    tick();
    checkOutput("restart_done_count", 32'(done_total[0] - base_done[0]), 32'(EXP_DONE_AT_LOCK));
    lockEpilogue(0);

    $display("[TB] reset during WAIT");
    applyStimulus(0, 8'h01, 0);
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (avm_read[0] && !wait_req[0]) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("rw_accept_seen", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rw_busy", 32'(busy[0]), 32'd0);
    checkOutput("rw_read", 32'(avm_read[0]), 32'd0);
    checkOutput("rw_done", 32'(done_s[0]), 32'd0);
    checkOutput("rw_poll_count", 32'(poll_count[0]), 32'd0);
    checkOutput("rw_locked", 32'(locked_s[0]), 32'd0);
    repeat (2) tick();
    checkOutput("rw_no_done", 32'(done_total[0] - base_done[0]), 32'd0);
    reset_n = 1'b1;
    tick();
    applyStimulus(0, 8'h01, 0);
    waitResult(0);
    checkOutput("after_rst_locked", 32'(locked_s[0]), 32'd1);
    checkOutput("after_rst_poll_count", 32'(poll_count[0]), 32'd4);
    lockEpilogue(0);

    $display("[TB] latency 3, gap 2");
    for (int k = 0; k < 16; k++) pat[1][k] = 32'h0000_0001;
    applyStimulus(1, 8'h01, 0);
    waitResult(1);
    checkOutput("lat_locked", 32'(locked_s[1]), 32'd1);
    checkOutput("lat_timeout", 32'(timeout_s[1]), 32'd0);
    checkOutput("lat_poll_count", 32'(poll_count[1]), 32'd4);
    for (int k = 0; k < 3; k++)
      checkOutput("spacing_b", 32'(acc_cyc[1][base_acc[1]+k+1] - acc_cyc[1][base_acc[1]+k]), 32'd7);
    tick();
    checkOutput("lat_done_count", 32'(done_total[1] - base_done[1]), 32'(EXP_DONE_AT_LOCK));
    lockEpilogue(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
